// File: rtl/psram_cr_seq.sv
// psram_cr_seq
// Runs the PSRAM software configuration-register access sequence on the
// asynchronous 16-bit PSRAM bus. Each request makes five accesses, all at the
// latched max address:
//   READ, READ, WRITE 16'h0000, WRITE select code, DATA.
// The DATA access is a WRITE of the CR data or a READ of the CR.
// Completion is signalled by a one-cycle dt_ack.
//
// Ports
//   apb_pclk      clock, shared with the APB slave
//   clr           synchronous active-high reset
//   dt_req        access request, held high by upstream until dt_ack
//   dt_ack        one-cycle completion pulse, data_from_cr valid with it
//   dt_rw         1 = CR write, 0 = CR read
//   data_to_cr    CR write data, [15:0] used
//   reg_addr      CR select code, [15:0] used
//   max_addr      PSRAM max address, [ADDR_W-1:0] used (ADDR_W <= 32)
//   data_from_cr  {16'h0, read data or write echo}, held until next ack
//   mem_addr      PSRAM word address
//   mem_dq_o      PSRAM write data
//   mem_dq_i      PSRAM read data
//   mem_dq_oe     drive enable for mem_dq_o
//   mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n   active-low strobes
module psram_cr_seq #(
   parameter int ADDR_W   = 24,
   parameter int T_SETUP  = 1,
   parameter int T_ACTIVE = 4,
   parameter int T_HOLD   = 1,
   parameter int T_GAP    = 2
) (
   input  logic              apb_pclk,
   input  logic              clr,
   input  logic              dt_req,
   output logic              dt_ack,
   input  logic              dt_rw,
   input  logic [31:0]       data_to_cr,
   input  logic [31:0]       reg_addr,
   input  logic [31:0]       max_addr,
   output logic [31:0]       data_from_cr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_dq_o,
   input  logic [15:0]       mem_dq_i,
   output logic              mem_dq_oe,
   output logic              mem_ce_n,
   output logic              mem_oe_n,
   output logic              mem_we_n,
   output logic              mem_lb_n,
   output logic              mem_ub_n
);

   localparam int T_MAX_SA = (T_SETUP > T_ACTIVE) ? T_SETUP : T_ACTIVE;
   localparam int T_MAX_HG = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
   localparam int T_MAX    = (T_MAX_SA > T_MAX_HG) ? T_MAX_SA : T_MAX_HG;
   // The timer counts from T_x-1 down to 0, so it never has to hold T_MAX itself.
   localparam int TW       = (T_MAX < 2) ? 1 : $clog2(T_MAX);

   localparam logic [TW-1:0] LD_SETUP  = TW'(T_SETUP - 1);
   localparam logic [TW-1:0] LD_ACTIVE = TW'(T_ACTIVE - 1);
   localparam logic [TW-1:0] LD_HOLD   = TW'(T_HOLD - 1);
   localparam logic [TW-1:0] LD_GAP    = TW'(T_GAP - 1);
   localparam logic [2:0]    LAST_STEP = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACTIVE,
      S_HOLD,
      S_GAP,
      S_ACK
   } state_t;

   state_t            r_state;
   state_t            w_state_n;
   logic [2:0]        r_step;
   logic [2:0]        w_step_n;
   logic [TW-1:0]     r_tmr;
   logic [TW-1:0]     w_tmr_n;
   logic              w_tmr_done;
   logic              w_accept;
   logic              w_sample;
   logic              w_load_dq;
   logic              w_busy_n;
   logic              w_wr_n;

   // Request values captured at acceptance; used for the whole sequence.
   logic              r_rw;
   logic [15:0]       r_sel;
   logic [15:0]       r_wdata;
   logic [15:0]       r_rdata;

   logic              r_ack;
   logic [15:0]       r_dout;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_dq_o;
   logic              r_dq_oe;
   logic              r_ce_n;
   logic              r_oe_n;
   logic              r_we_n;

   // Only the low bits of the 32-bit APB-side buses are consumed.
   logic              w_unused;
   assign w_unused = ^{data_to_cr, reg_addr, max_addr};

   // Steps 2 and 3 always write; step 4 writes only for a CR write.
   function automatic logic f_is_wr(input logic [2:0] step, input logic rw);
      return (step == 3'd2) || (step == 3'd3) || ((step == LAST_STEP) && rw);
   endfunction

   function automatic logic [15:0] f_wr_data(input logic [2:0] step,
                                             input logic [15:0] sel,
                                             input logic [15:0] wdata);
      logic [15:0] d;
      d = 16'h0000;
      case (step)
         3'd3:    d = sel;
         3'd4:    d = wdata;
         default: d = 16'h0000;
      endcase
      return d;
   endfunction

   always_comb begin
      w_state_n  = r_state;
      w_step_n   = r_step;
      w_tmr_n    = r_tmr;
      w_accept   = 1'b0;
      w_sample   = 1'b0;
      w_tmr_done = (r_tmr == '0);

      case (r_state)
         S_IDLE: begin
            if (dt_req) begin
               w_state_n = S_SETUP;
               w_step_n  = 3'd0;
               w_tmr_n   = LD_SETUP;
               w_accept  = 1'b1;
            end
         end
         S_SETUP: begin
            if (w_tmr_done) begin
               w_state_n = S_ACTIVE;
               w_tmr_n   = LD_ACTIVE;
            end else begin
               w_tmr_n = r_tmr - TW'(1);
            end
         end
         S_ACTIVE: begin
            if (w_tmr_done) begin
               w_state_n = S_HOLD;
               w_tmr_n   = LD_HOLD;
               // Read data is captured on the edge that ends the strobe.
               w_sample  = (r_step == LAST_STEP) && !r_rw;
            end else begin
               w_tmr_n = r_tmr - TW'(1);
            end
         end
         S_HOLD: begin
            if (w_tmr_done) begin
               w_state_n = S_GAP;
               w_tmr_n   = LD_GAP;
            end else begin
               w_tmr_n = r_tmr - TW'(1);
            end
         end
         S_GAP: begin
            if (w_tmr_done) begin
               if (r_step == LAST_STEP) begin
                  w_state_n = S_ACK;
               end else begin
                  w_state_n = S_SETUP;
                  w_step_n  = r_step + 3'd1;
                  w_tmr_n   = LD_SETUP;
               end
            end else begin
               w_tmr_n = r_tmr - TW'(1);
            end
         end
         S_ACK: begin
            w_state_n = S_IDLE;
         end
         default: begin
            w_state_n = S_IDLE;
         end
      endcase

      // Bus strobes are registered from the next state so the pins come
      // straight off flops and line up with the state they belong to.
      // On acceptance the next step is 0, a read, so the stale r_rw is harmless.
      w_busy_n  = (w_state_n == S_SETUP) || (w_state_n == S_ACTIVE) ||
                  (w_state_n == S_HOLD);
      w_wr_n    = f_is_wr(w_step_n, r_rw);
      w_load_dq = (w_state_n == S_SETUP) && (r_state != S_SETUP);
   end

   always_ff @(posedge apb_pclk) begin
      if (clr) begin
         r_state <= S_IDLE;
         r_step  <= 3'd0;
         r_tmr   <= '0;
         r_ack   <= 1'b0;
         r_dout  <= 16'h0000;
         r_addr  <= '0;
         r_dq_o  <= 16'h0000;
         r_dq_oe <= 1'b0;
         r_ce_n  <= 1'b1;
         r_oe_n  <= 1'b1;
         r_we_n  <= 1'b1;
      end else begin
         r_state <= w_state_n;
         r_step  <= w_step_n;
         r_tmr   <= w_tmr_n;
         r_ack   <= (w_state_n == S_ACK);
         r_ce_n  <= !w_busy_n;
         r_dq_oe <= w_busy_n && w_wr_n;
         r_oe_n  <= !((w_state_n == S_ACTIVE) && !w_wr_n);
         r_we_n  <= !((w_state_n == S_ACTIVE) && w_wr_n);
         if (w_accept) begin
            r_addr <= max_addr[ADDR_W-1:0];
         end
         if (w_load_dq) begin
            r_dq_o <= f_wr_data(w_step_n, r_sel, r_wdata);
         end
         if (w_state_n == S_ACK) begin
            r_dout <= r_rw ? r_wdata : r_rdata;
         end
      end
   end

   // Request capture and read data: only consumed under FSM control.
   always_ff @(posedge apb_pclk) begin
      if (w_accept) begin
         r_rw    <= dt_rw;
         r_sel   <= reg_addr[15:0];
         r_wdata <= data_to_cr[15:0];
      end
      if (w_sample) begin
         r_rdata <= mem_dq_i;
      end
   end

   assign dt_ack       = r_ack;
   assign data_from_cr = {16'h0000, r_dout};
   assign mem_addr     = r_addr;
   assign mem_dq_o     = r_dq_o;
   assign mem_dq_oe    = r_dq_oe;
   assign mem_ce_n     = r_ce_n;
   assign mem_lb_n     = r_ce_n;
   assign mem_ub_n     = r_ce_n;
   assign mem_oe_n     = r_oe_n;
   assign mem_we_n     = r_we_n;

endmodule

// File: tb/tb_psram_cr_seq.sv
// Testbench for psram_cr_seq: a default-timing instance and a 2/3/1/1 instance.
// Bus activity is recorded per cycle and decoded back into accesses, which are
// compared with the access list expected for the request.
module tb_psram_cr_seq;

   logic        apb_pclk = 1'b0;
   logic        clr;
   logic        dt_req;
   logic        dt_req2;
   logic        dt_rw;
   logic [31:0] data_to_cr;
   logic [31:0] reg_addr;
   logic [31:0] max_addr;
   logic [15:0] mem_dq_i;

   logic        dt_ack;
   logic [31:0] data_from_cr;
   logic [23:0] mem_addr;
   logic [15:0] mem_dq_o;
   logic        mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n;

   logic        d2_ack;
   logic [31:0] d2_dout;
   logic [23:0] d2_addr;
   logic [15:0] d2_dq_o;
   logic        d2_dq_oe, d2_ce_n, d2_oe_n, d2_we_n, d2_lb_n, d2_ub_n;

   int total = 0;
   int bad   = 0;
   int cyc_cnt = 0;

   psram_cr_seq u_dut (
      .apb_pclk(apb_pclk), .clr(clr), .dt_req(dt_req), .dt_ack(dt_ack),
      .dt_rw(dt_rw), .data_to_cr(data_to_cr), .reg_addr(reg_addr),
      .max_addr(max_addr), .data_from_cr(data_from_cr), .mem_addr(mem_addr),
      .mem_dq_o(mem_dq_o), .mem_dq_i(mem_dq_i), .mem_dq_oe(mem_dq_oe),
      .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
      .mem_lb_n(mem_lb_n), .mem_ub_n(mem_ub_n)
   );

   psram_cr_seq #(.T_SETUP(2), .T_ACTIVE(3), .T_HOLD(1), .T_GAP(1)) u_dut2 (
      .apb_pclk(apb_pclk), .clr(clr), .dt_req(dt_req2), .dt_ack(d2_ack),
      .dt_rw(dt_rw), .data_to_cr(data_to_cr), .reg_addr(reg_addr),
      .max_addr(max_addr), .data_from_cr(d2_dout), .mem_addr(d2_addr),
      .mem_dq_o(d2_dq_o), .mem_dq_i(mem_dq_i), .mem_dq_oe(d2_dq_oe),
      .mem_ce_n(d2_ce_n), .mem_oe_n(d2_oe_n), .mem_we_n(d2_we_n),
      .mem_lb_n(d2_lb_n), .mem_ub_n(d2_ub_n)
   );

   always #5 apb_pclk = ~apb_pclk;
   always @(posedge apb_pclk) cyc_cnt <= cyc_cnt + 1;

   // Per-cycle bus record of one transaction (index = cycle after request).
   logic        a_ce[0:255];
   logic        a_oe[0:255];
   logic        a_we[0:255];
   logic        a_dqoe[0:255];
   logic [23:0] a_addr[0:255];
   logic [15:0] a_dq[0:255];
   int          n_cyc, ack_cyc, ack_abs, prev_abs;
   logic [31:0] ack_data;
   logic        lbub_bad;
   logic        got_ack;

   // Expected request contents.
   logic        e_rw;
   logic [23:0] e_addr;
   logic [15:0] e_sel, e_wdata, rdval;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setup(input logic rw, input logic [31:0] mx, input logic [31:0] sl,
                        input logic [31:0] wd, input logic [15:0] rv);
      dt_rw = rw; max_addr = mx; reg_addr = sl; data_to_cr = wd; rdval = rv;
      e_rw = rw; e_addr = mx[23:0]; e_sel = sl[15:0]; e_wdata = wd[15:0];
   endtask

   // Called at a negedge: raises the request in that cycle (cycle 0) and records
   // cycles 1.. until ack, stop_at, or the cycle budget. The PSRAM model returns
   // rdval during the fifth access and 16'hDEAD otherwise.
   task automatic run_txn(input int sel, input int stop_at, input bit chg);
      int   live;
      logic ce, oe, we, lb, ub, dqoe, ack;
      logic [23:0] ad;
      logic [15:0] dq;
      logic [31:0] dout;
      live = 0; ack_cyc = -1; n_cyc = 0; lbub_bad = 1'b0;
      a_ce[0] = 1'b1; a_oe[0] = 1'b1; a_we[0] = 1'b1; a_dqoe[0] = 1'b0;
      if (sel == 0) dt_req = 1'b1; else dt_req2 = 1'b1;
      for (int c = 1; c <= 250; c++) begin
         @(negedge apb_pclk);
         if (sel == 0) begin
            ce = mem_ce_n; oe = mem_oe_n; we = mem_we_n; lb = mem_lb_n; ub = mem_ub_n;
            dqoe = mem_dq_oe; ad = mem_addr; dq = mem_dq_o; ack = dt_ack; dout = data_from_cr;
         end else begin
            ce = d2_ce_n; oe = d2_oe_n; we = d2_we_n; lb = d2_lb_n; ub = d2_ub_n;
            dqoe = d2_dq_oe; ad = d2_addr; dq = d2_dq_o; ack = d2_ack; dout = d2_dout;
         end
         n_cyc = c;
         a_ce[c] = ce; a_oe[c] = oe; a_we[c] = we; a_dqoe[c] = dqoe; a_addr[c] = ad; a_dq[c] = dq;
         if (lb !== ce || ub !== ce) lbub_bad = 1'b1;
         if (!ce && a_ce[c-1]) live++;
         mem_dq_i = (live == 5 && !ce) ? rdval : 16'hDEAD;
         if (chg && c == 1) begin
            data_to_cr = $urandom; reg_addr = $urandom; max_addr = $urandom; dt_rw = ~dt_rw;
         end
         if (ack) begin
            ack_cyc = c; ack_abs = cyc_cnt; ack_data = dout;
            dt_req = 1'b0; dt_req2 = 1'b0;
            break;
         end
         if (c == stop_at) break;
      end
   endtask

   // Decode the recorded waveform into accesses and compare with the expected list.
   task automatic analyze(input int ts, input int ta, input int th, input int tg);
      int st[8], sf[8], sl[8], en[8], dqn[8];
      logic wr[8], rd[8];
      logic [15:0] dt[8];
      logic xw[5];
      logic [15:0] xd[5];
      int k, gap;
      bit ovl, outside, addr_moved;
      xw = '{1'b0, 1'b0, 1'b1, 1'b1, e_rw};
      xd = '{16'h0, 16'h0, 16'h0000, e_sel, e_wdata};
      k = -1; ovl = 0; outside = 0; addr_moved = 0;
      for (int c = 1; c <= n_cyc; c++) begin
         if (!a_oe[c] && !a_we[c]) ovl = 1;
         if (a_ce[c]) begin
            if (!a_oe[c] || !a_we[c] || a_dqoe[c]) outside = 1;
         end else begin
            if (a_ce[c-1]) begin
               k++;
               if (k < 8) begin
                  st[k] = c; sf[k] = -1; sl[k] = -1; en[k] = c; dqn[k] = 0;
                  wr[k] = 0; rd[k] = 0; dt[k] = 16'h0;
               end
            end
            if (k >= 0 && k < 8) begin
               en[k] = c;
               if (a_addr[c] !== e_addr) addr_moved = 1;
               if (a_dqoe[c]) dqn[k]++;
               if (!a_we[c]) begin wr[k] = 1; dt[k] = a_dq[c]; end
               if (!a_oe[c]) rd[k] = 1;
               if (!a_oe[c] || !a_we[c]) begin
                  if (sf[k] < 0) sf[k] = c;
                  sl[k] = c;
               end
            end
         end
      end
      chk("n_access", k + 1, 5);
      chk("ack_cycle", ack_cyc, 5 * (ts + ta + th + tg) + 1);
      chk("oe_we_overlap", ovl, 0);
      chk("strobe_outside_ce", outside, 0);
      chk("addr_not_max", addr_moved, 0);
      chk("lb_ub_follow_ce", lbub_bad, 0);
      for (int i = 0; i < 5 && i <= k && i < 8; i++) begin
         chk($sformatf("kind%0d", i), {wr[i], rd[i]}, xw[i] ? 2'b10 : 2'b01);
         if (xw[i]) chk($sformatf("wdata%0d", i), dt[i], xd[i]);
         chk($sformatf("dq_oe%0d", i), dqn[i], xw[i] ? (ts + ta + th) : 0);
         gap = (i < 4 && i < k) ? (st[i+1] - en[i] - 1) : (ack_cyc - en[i] - 1);
         chk($sformatf("timing%0d", i),
             {8'(sf[i] - st[i]), 8'(sl[i] - sf[i] + 1), 8'(en[i] - sl[i]), 8'(gap)},
             {8'(ts), 8'(ta), 8'(th), 8'(tg)});
      end
      chk("data_from_cr", ack_data, {16'h0, e_rw ? e_wdata : rdval});
   endtask

   initial begin
      clr = 1'b1; dt_req = 1'b0; dt_req2 = 1'b0; dt_rw = 1'b0;
      data_to_cr = 32'h0; reg_addr = 32'h0; max_addr = 32'h0;
      mem_dq_i = 16'hDEAD; rdval = 16'h0; prev_abs = 0;
      repeat (3) @(negedge apb_pclk);
      chk("rst_ctl", {dt_ack, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n}, 7'b0011111);
      chk("rst_dout", data_from_cr, 32'h0);
      chk("rst_addr_dq", {mem_addr, mem_dq_o}, 40'h0);
      chk("rst_ctl2", {d2_ack, d2_dq_oe, d2_ce_n, d2_oe_n, d2_we_n, d2_lb_n, d2_ub_n}, 7'b0011111);
      clr = 1'b0;
      @(negedge apb_pclk);

      // CR write
      setup(1'b1, 32'h00FFFFFF, 32'h0000_0001, 32'hAB12_8F1F, 16'h0);
      run_txn(0, 0, 0);
      analyze(1, 4, 1, 2);
      repeat (3) @(negedge apb_pclk);
      chk("dout_hold", data_from_cr, 32'h0000_8F1F);

      // CR read
      setup(1'b0, 32'h00FFFFFF, 32'h0000_0000, 32'h1234_5678, 16'h0010);
      run_txn(0, 0, 0);
      analyze(1, 4, 1, 2);
      @(negedge apb_pclk);

      // Back-to-back random requests; inputs scrambled after acceptance
      for (int t = 0; t < 4; t++) begin
         setup(1'($urandom), $urandom, $urandom, $urandom, 16'($urandom));
         run_txn(0, 0, 1);
         analyze(1, 4, 1, 2);
         if (t > 0) chk("b2b_spacing", ack_abs - prev_abs, 42);
         prev_abs = ack_abs;
         @(negedge apb_pclk);
         chk("ack_one_cycle", dt_ack, 1'b0);
      end

      // Alternate timing instance
      setup(1'b1, $urandom, $urandom, $urandom, 16'($urandom));
      run_txn(1, 0, 0);
      analyze(2, 3, 1, 1);
      @(negedge apb_pclk);
      setup(1'b0, $urandom, $urandom, $urandom, 16'($urandom));
      run_txn(1, 0, 0);
      analyze(2, 3, 1, 1);
      @(negedge apb_pclk);

      // Reset during step-2 write strobe
      setup(1'b1, $urandom, $urandom, $urandom, 16'($urandom));
      run_txn(0, 19, 0);
      chk("pre_rst_write_active", {a_we[19], a_ce[19]}, 2'b00);
      clr = 1'b1; dt_req = 1'b0;
      @(negedge apb_pclk);
      chk("abort_ctl", {dt_ack, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n}, 7'b0011111);
      chk("abort_dout", data_from_cr, 32'h0);
      chk("abort_addr_dq", {mem_addr, mem_dq_o}, 40'h0);
      clr = 1'b0;
      got_ack = 1'b0;
      repeat (50) begin
         @(negedge apb_pclk);
         if (dt_ack) got_ack = 1'b1;
      end
      chk("no_ack_after_abort", got_ack, 1'b0);
      setup(1'($urandom), $urandom, $urandom, $urandom, 16'($urandom));
      run_txn(0, 0, 0);
      analyze(1, 4, 1, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
